free_list_reclaim: RTL
======================

Name: free_list_reclaim

Overview:
Retire-side producer for the rename free list. It takes up to two committed instructions per cycle and collects each one's previous physical destination (old_rd). It packs the freed registers into 12-bit pairs, {hi, lo}, which is the same format the rename stage pops, and writes those pairs back into the free-list FIFO. It sits between the commit stage and the free list's write port, with backpressure toward commit.

Parameters:
PhysAddrWidth, 6, width of one physical register index
PairWidth, 2*PhysAddrWidth (12), width of one free-list entry

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
init_busy_i  in  1  free list is being initialised by the rename FSM; reclaim must not write
commit_valid_i  in  1  commit bundle valid
commit_ready_o  out  1  bundle accepted when valid and ready are both high
commit_free_0_i  in  1  lane 0 releases old_rd (valid instruction with an arch rd write)
commit_old_rd_0_i  in  PhysAddrWidth  lane 0 physical register being freed
commit_free_1_i  in  1  lane 1 releases old_rd
commit_old_rd_1_i  in  PhysAddrWidth  lane 1 physical register being freed
list_full_i  in  1  free-list FIFO full
list_wr_o  out  1  free-list write strobe
list_din_o  out  PairWidth  {hi, lo} pair written to the free list
hold_valid_o  out  1  one freed register is parked, waiting for a partner

Behaviour:
- Reset is asynchronous and active-high. During and after reset:
  - hold_valid_q=0, hold_reg_q=0
  - out_valid_q=0, out_pair_q=0
  - list_wr_o=0, list_din_o=0, commit_ready_o=0 while rst_i is high
- Lane filtering:
  - A lane is a candidate when commit_free_x_i=1 and commit_old_rd_x_i!=0.
  - Physical register 0 is never reclaimed and is silently dropped.
- Storage: one hold slot (a single parked register) and one output register (one pair).
- commit_ready_o = !init_busy_i && (!out_valid_q || !list_full_i).
- list_wr_o = out_valid_q && !list_full_i && !init_busy_i. list_din_o = out_pair_q. The write fires on that strobe.
- On a fire, out_valid_q clears, unless it is reloaded in the same cycle.
- On an accepted bundle, candidates are ordered hold, then lane 0, then lane 1. With count = number of candidates:
  - count 0: no change.
  - count 1: the candidate goes to the hold slot (hold_valid_q=1).
  - count 2: the output register loads {second, first}; the hold slot clears.
  - count 3: the output register loads {lane0, hold}; the hold slot takes lane 1.
- Output latency: a pair completed by an accepted bundle appears on list_wr_o the next cycle, provided list_full_i=0.
- Simultaneous drain and load: in the same cycle, the output register may write out its current pair and reload with a new one. Throughput is one pair per cycle.
- If list_full_i stays high:
  - out_valid_q holds, and out_pair_q is stable.
  - commit_ready_o=0.
  - The hold slot is untouched.
- A freed register is never lost or duplicated. The hold slot never exceeds one entry; count>=2 always empties to at most one leftover.
- init_busy_i high:
  - no writes, no acceptance
  - the state is frozen
- No flush input. Committed frees are architectural and are always returned.
- Parked register: an odd leftover stays in the hold slot indefinitely until a partner arrives. This is by design, because the free list pops in pairs.

Optional Feature:
RECLAIM_STATS_EN. When defined, two things are added:
- Output port reclaimed_cnt_o (32 bits, reset 0). It increments by 2 on every list_wr_o fire and saturates at 32'hFFFF_FFFF.
- A simulation assertion. It flags list_wr_o while list_full_i=1, and any commit acceptance while out_valid_q && list_full_i.

When not defined, the port and the assertions are absent, and the behaviour is otherwise identical.

Test Plan:
- Reset, then bundle lane0=33 and lane1=34, both free, list_full_i=0 -> next cycle list_wr_o=1, list_din_o={6'd34, 6'd33}; hold_valid_o=0.
- Bundle lane0=40 only -> hold_valid_o=1, no write. Next bundle lane0=41 and lane1=42 -> list_din_o={41, 40}, hold_valid_o=1 holding 42.
- Bundle with old_rd=0 on lane0 and 45 on lane1 -> 0 dropped; hold_valid_o=1 with 45; no write.
- A pair is pending and list_full_i=1 for 3 cycles -> commit_ready_o=0, list_wr_o=0, list_din_o stable. list_full_i drops -> one write of the same pair, and commit_ready_o=1.
- init_busy_i=1 with a pending pair and a valid bundle -> no write, no accept. Release -> the pair is written the same cycle.
- Assert rst_i asynchronously mid-stream, with hold and output both valid -> list_wr_o and hold_valid_o go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/free_list_reclaim_if.sv
// Commit-side and free-list-side signals of the reclaim block, bundled.
//   master : commit stage plus free-list environment (drives bundles, full, init_busy)
//   slave  : free_list_reclaim (drives ready, write strobe, write data, hold flag)
// Signals:
//   init_busy             free list is being initialised, reclaim stays idle
//   commit_valid/ready    commit bundle handshake
//   commit_free_0/1       lane releases its old_rd
//   commit_old_rd_0/1     physical register being freed on each lane
//   list_full             free-list FIFO full
//   list_wr / list_din    free-list write strobe and {hi, lo} pair
//   hold_valid            one freed register is parked waiting for a partner
interface free_list_reclaim_if #(
   parameter int PhysAddrWidth = 6
);
   localparam int PairWidth = 2 * PhysAddrWidth;

   logic                     init_busy;
   logic                     commit_valid;
   logic                     commit_ready;
   logic                     commit_free_0;
   logic [PhysAddrWidth-1:0] commit_old_rd_0;
   logic                     commit_free_1;
   logic [PhysAddrWidth-1:0] commit_old_rd_1;
   logic                     list_full;
   logic                     list_wr;
   logic [PairWidth-1:0]     list_din;
   logic                     hold_valid;

   modport master (
      output init_busy, commit_valid, commit_free_0, commit_old_rd_0,
             commit_free_1, commit_old_rd_1, list_full,
      input  commit_ready, list_wr, list_din, hold_valid
   );

   modport slave (
      input  init_busy, commit_valid, commit_free_0, commit_old_rd_0,
             commit_free_1, commit_old_rd_1, list_full,
      output commit_ready, list_wr, list_din, hold_valid
   );
endinterface

// File: rtl/free_list_reclaim.sv
// Retire-side producer for the rename free list. Collects up to two freed
// physical registers per commit bundle, packs them into {hi, lo} pairs and
// writes the pairs into the free-list FIFO, back-pressuring commit.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset
//   bus     free_list_reclaim_if.slave (commit handshake, free-list write port)
//   reclaimed_cnt_o  (only with RECLAIM_STATS_EN) saturating count of
//                    registers returned, +2 per write
// Optional build macro: RECLAIM_STATS_EN adds reclaimed_cnt_o and
// simulation assertions on the free-list protocol.
module free_list_reclaim #(
   parameter int PhysAddrWidth = 6,
   parameter int PairWidth     = 2 * PhysAddrWidth
) (
   input  logic clk_i,
   input  logic rst_i,
   free_list_reclaim_if.slave bus
`ifdef RECLAIM_STATS_EN
   ,
   output logic [31:0] reclaimed_cnt_o
`endif
);

   logic                     hold_valid_q;
   logic [PhysAddrWidth-1:0] hold_reg_q;
   logic                     out_valid_q;
   logic [PairWidth-1:0]     out_pair_q;

   logic                     cand0, cand1;
   logic [1:0]               cnt;
   logic [PhysAddrWidth-1:0] first, second;
   logic                     ready, fire, accept;

   // Physical register 0 is never reclaimed.
   assign cand0 = bus.commit_free_0 && (bus.commit_old_rd_0 != '0);
   assign cand1 = bus.commit_free_1 && (bus.commit_old_rd_1 != '0);
   assign cnt   = {1'b0, hold_valid_q} + {1'b0, cand0} + {1'b0, cand1};

   // Candidates ordered hold, lane 0, lane 1.
   always_comb begin
      first  = '0;
      second = '0;
      if (hold_valid_q) begin
         first  = hold_reg_q;
         second = cand0 ? bus.commit_old_rd_0 : bus.commit_old_rd_1;
      end else begin
         first  = cand0 ? bus.commit_old_rd_0 : bus.commit_old_rd_1;
         second = bus.commit_old_rd_1;
      end
   end

   // Ready only when the output register is empty or drains this cycle, so a
   // load never overwrites an unwritten pair.
   assign ready  = !rst_i && !bus.init_busy && (!out_valid_q || !bus.list_full);
   assign fire   = out_valid_q && !bus.list_full && !bus.init_busy;
   assign accept = bus.commit_valid && ready;

   assign bus.commit_ready = ready;
   assign bus.list_wr      = fire;
   assign bus.list_din     = out_pair_q;
   assign bus.hold_valid   = hold_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_valid_q <= 1'b0;
         hold_reg_q   <= '0;
         out_valid_q  <= 1'b0;
         out_pair_q   <= '0;
      end else begin
         if (fire) out_valid_q <= 1'b0;
         if (accept) begin
            case (cnt)
               2'd1: begin
                  hold_valid_q <= 1'b1;
                  hold_reg_q   <= first;
               end
               2'd2: begin
                  out_valid_q  <= 1'b1;
                  out_pair_q   <= {second, first};
                  hold_valid_q <= 1'b0;
               end
               2'd3: begin
                  out_valid_q  <= 1'b1;
                  out_pair_q   <= {bus.commit_old_rd_0, hold_reg_q};
                  hold_reg_q   <= bus.commit_old_rd_1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef RECLAIM_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         reclaimed_cnt_o <= '0;
      end else if (fire) begin
         if (reclaimed_cnt_o >= 32'hFFFF_FFFD) reclaimed_cnt_o <= 32'hFFFF_FFFF;
         else                                  reclaimed_cnt_o <= reclaimed_cnt_o + 32'd2;
      end
   end

   a_no_wr_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.list_wr && bus.list_full));
   a_no_accept_when_blocked: assert property (@(posedge clk_i) disable iff (rst_i)
      !(accept && out_valid_q && bus.list_full));
`endif

endmodule
